// File: rtl/tis_console_io_if.sv
// Host <-> TIS100 console bundle: host input/output streams, TIS100 buffer side, status.
// slave is the console block; master is whatever drives the host and TIS100 sides.
interface tis_console_io_if;
  logic [10:0] hostInData;
  logic [1:0]  hostInSel;
  logic        hostInValid;
  logic        hostInReady;

  // writeIn is declared [0:3] so that index 0 is the leftmost bit
  logic [10:0] inData;
  logic [0:3]  writeIn;
  logic [3:0]  full;

  logic [10:0] outData;
  logic [1:0]  dataFrom;
  logic        dataReady;
  logic        read;

  logic [10:0] hostOutData;
  logic [1:0]  hostOutFrom;
  logic        hostOutValid;
  logic        hostOutReady;

  logic        clearFlags;
  logic        badSel;
  logic        stall;
  logic [15:0] inCount;
  logic [15:0] outCount;

  modport slave (
    input  hostInData, hostInSel, hostInValid, full, outData, dataFrom, dataReady,
           hostOutReady, clearFlags,
    output hostInReady, inData, writeIn, read, hostOutData, hostOutFrom, hostOutValid,
           badSel, stall, inCount, outCount
  );

  modport master (
    output hostInData, hostInSel, hostInValid, full, outData, dataFrom, dataReady,
           hostOutReady, clearFlags,
    input  hostInReady, inData, writeIn, read, hostOutData, hostOutFrom, hostOutValid,
           badSel, stall, inCount, outCount
  );
endinterface

// File: rtl/tis_console_io.sv
// Console bridge: host words -> TIS100 input buffers (strobe + settle cycle),
// TIS100 output buffer -> single-entry host holding register, plus sticky status and counters.
module tis_console_io #(
  parameter logic [3:0]  INPUT_MASK     = 4'b1001,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  tis_console_io_if.slave  io
);

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IN_IDLE, IN_STROBE, IN_HOLD} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_POP, OUT_WAIT} out_state_e;

  in_state_e   in_state_q,  in_state_d;
  logic [10:0] in_buf_q,    in_buf_d;
  logic [1:0]  in_sel_q,    in_sel_d;
  logic [10:0] in_data_q,   in_data_d;
  logic [15:0] in_cnt_q,    in_cnt_d;
  logic [15:0] wd_q,        wd_d;
  logic        bad_sel_q,   bad_sel_d;
  logic        stall_q,     stall_d;

  out_state_e  out_state_q, out_state_d;
  logic [10:0] out_dat_q,   out_dat_d;
  logic [1:0]  out_from_q,  out_from_d;
  logic        out_vld_q,   out_vld_d;
  logic [15:0] out_cnt_q,   out_cnt_d;

  logic        sel_exists;
  logic        in_rdy;
  logic        accept;
  logic        wd_inc;
  logic [0:3]  write_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_q  <= IN_IDLE;
      in_buf_q    <= '0;
      in_sel_q    <= '0;
      in_data_q   <= '0;
      in_cnt_q    <= '0;
      wd_q        <= '0;
      bad_sel_q   <= 1'b0;
      stall_q     <= 1'b0;
      out_state_q <= OUT_IDLE;
      out_dat_q   <= '0;
      out_from_q  <= '0;
      out_vld_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      in_state_q  <= in_state_d;
      in_buf_q    <= in_buf_d;
      in_sel_q    <= in_sel_d;
      in_data_q   <= in_data_d;
      in_cnt_q    <= in_cnt_d;
      wd_q        <= wd_d;
      bad_sel_q   <= bad_sel_d;
      stall_q     <= stall_d;
      out_state_q <= out_state_d;
      out_dat_q   <= out_dat_d;
      out_from_q  <= out_from_d;
      out_vld_q   <= out_vld_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  // Input path: words to absent nodes are always accepted (and dropped) so they never block.
  always_comb begin
    in_state_d = in_state_q;
    in_buf_d   = in_buf_q;
    in_sel_d   = in_sel_q;
    in_data_d  = in_data_q;
    in_cnt_d   = in_cnt_q;
    wd_d       = wd_q;
    bad_sel_d  = bad_sel_q;
    stall_d    = stall_q;
    write_in   = '0;

    sel_exists = INPUT_MASK[io.hostInSel];
    in_rdy     = (in_state_q == IN_IDLE) && (!sel_exists || !io.full[io.hostInSel]);
    accept     = io.hostInValid && in_rdy;
    wd_inc     = (in_state_q == IN_IDLE) && io.hostInValid && !in_rdy && (wd_q != TIMEOUT);

    if (io.clearFlags) begin
      bad_sel_d = 1'b0;
      stall_d   = 1'b0;
    end

    if (accept || io.clearFlags) begin
      wd_d = '0;
    end else if (wd_inc) begin
      wd_d = wd_q + 16'd1;
    end

    // Set events are applied after the clear so they win in the same cycle.
    if (wd_inc && (wd_q == TIMEOUT - 16'd1)) begin
      stall_d = 1'b1;
    end

    case (in_state_q)
      IN_IDLE: begin
        if (accept) begin
          if (sel_exists) begin
            in_buf_d   = io.hostInData;
            in_sel_d   = io.hostInSel;
            in_state_d = IN_STROBE;
          end else begin
            bad_sel_d  = 1'b1;
          end
        end
      end
      IN_STROBE: begin
        write_in[in_sel_q] = 1'b1;
        in_data_d  = in_buf_q;
        in_cnt_d   = in_cnt_q + 16'd1;
        in_state_d = IN_HOLD;
      end
      IN_HOLD: begin
        in_state_d = IN_IDLE;
      end
      default: begin
        in_state_d = IN_IDLE;
      end
    endcase
  end

  // Output path: at most one word in flight; the pop strobe follows the capture.
  always_comb begin
    out_state_d = out_state_q;
    out_dat_d   = out_dat_q;
    out_from_d  = out_from_q;
    out_vld_d   = out_vld_q;
    out_cnt_d   = out_cnt_q;

    if (out_vld_q && io.hostOutReady) begin
      out_vld_d = 1'b0;
    end

    case (out_state_q)
      OUT_IDLE: begin
        if (io.dataReady && !out_vld_q) begin
          out_dat_d   = io.outData;
          out_from_d  = io.dataFrom;
          out_vld_d   = 1'b1;
          out_state_d = OUT_POP;
        end
      end
      OUT_POP: begin
        out_cnt_d   = out_cnt_q + 16'd1;
        out_state_d = OUT_WAIT;
      end
      OUT_WAIT: begin
        out_state_d = OUT_IDLE;
      end
      default: begin
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  assign io.hostInReady  = in_rdy;
  assign io.writeIn      = write_in;
  assign io.inData       = (in_state_q == IN_STROBE) ? in_buf_q : in_data_q;
  assign io.read         = (out_state_q == OUT_POP);
  assign io.hostOutData  = out_dat_q;
  assign io.hostOutFrom  = out_from_q;
  assign io.hostOutValid = out_vld_q;
  assign io.badSel       = bad_sel_q;
  assign io.stall        = stall_q;
  assign io.inCount      = in_cnt_q;
  assign io.outCount     = out_cnt_q;

endmodule

// File: doc/tis_console_io.md
TIS_CONSOLE_IO -- requirements
Module: tis_console_io

Interface
REQ-001 Parameter INPUT_MASK, default 4'b1001: bit n set means TIS100 input node n exists and is writable; bit 0 maps to writeIn[0].
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: input-stall watchdog threshold, range 1..65535.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 hostInData  in  11  word from host, destined for a TIS100 input node.
REQ-006 hostInSel  in  2  target input node index 0..3.
REQ-007 hostInValid  in  1  host word present.
REQ-008 hostInReady  out  1  word accepted on the edge where hostInValid=1 and hostInReady=1.
REQ-009 inData  out  11  data to TIS100 input buffers.
REQ-010 writeIn  out  4  one-hot write strobe to TIS100 input buffers; index 0 is leftmost.
REQ-011 full  in  4  TIS100 input-buffer full flags.
REQ-012 outData  in  11  TIS100 output-buffer head word; valid while dataReady=1.
REQ-013 dataFrom  in  2  TIS100 output index of outData.
REQ-014 dataReady  in  1  TIS100 output buffer non-empty.
REQ-015 read  out  1  one-cycle pop strobe to TIS100 output buffer.
REQ-016 hostOutData  out  11  result word to host.
REQ-017 hostOutFrom  out  2  output index of hostOutData.
REQ-018 hostOutValid  out  1  result word held.
REQ-019 hostOutReady  in  1  host consumes on hostOutValid=1 and hostOutReady=1.
REQ-020 clearFlags  in  1  synchronous clear of badSel, stall, and watchdog count.
REQ-021 badSel  out  1  sticky: word addressed to a masked-off node was dropped.
REQ-022 stall  out  1  sticky: watchdog expired.
REQ-023 inCount  out  16  words written to TIS100; wraps 65535->0.
REQ-024 outCount  out  16  words read from TIS100; wraps 65535->0.

Function
REQ-025 The input FSM shall have states IN_IDLE, IN_STROBE, IN_HOLD.
REQ-026 hostInReady shall be 1 only in IN_IDLE, and then only when INPUT_MASK[hostInSel]=0 or full[hostInSel]=0.
REQ-027 On acceptance with INPUT_MASK[hostInSel]=0: word dropped, badSel set next edge, FSM stays IN_IDLE, inCount unchanged.
REQ-028 On acceptance with the mask bit set: register data and index, go to IN_STROBE.
REQ-029 In IN_STROBE: writeIn[index]=1 for exactly one cycle, inData=registered word, inCount increments; next state IN_HOLD.
REQ-030 IN_HOLD shall last one cycle, with writeIn=0, so that full can update; next state IN_IDLE; throughput one word per 3 cycles maximum.
REQ-031 writeIn shall be 0 outside IN_STROBE; inData shall hold the last written word.
REQ-032 Watchdog: a 16-bit count increments each cycle in IN_IDLE with hostInValid=1 and hostInReady=0, saturates at TIMEOUT_CYCLES, sets stall on reaching it, and clears on any acceptance or clearFlags.
REQ-033 The output FSM shall have states OUT_IDLE, OUT_POP, OUT_WAIT.
REQ-034 In OUT_IDLE with dataReady=1 and hostOutValid=0: capture outData/dataFrom into hostOutData/hostOutFrom, set hostOutValid, go to OUT_POP.
REQ-035 In OUT_POP: read=1 for exactly one cycle and outCount increments; next state OUT_WAIT.
REQ-036 OUT_WAIT shall last one cycle with read=0; next state OUT_IDLE.
REQ-037 hostOutValid shall clear on the edge where hostOutValid=1 and hostOutReady=1; a new capture shall not occur in that same cycle.
REQ-038 hostOutData/hostOutFrom shall stay stable while hostOutValid=1.
REQ-039 Input and output paths shall be independent; simultaneous activity on both is legal.
REQ-040 clearFlags and a badSel/stall set event in the same cycle: set wins.

Reset
REQ-041 rst=0 shall immediately force: both FSMs idle; writeIn=0, read=0, hostOutValid=0, badSel=0, stall=0, inCount=0, outCount=0, watchdog=0, inData=0, hostOutData=0, hostOutFrom=0.
REQ-042 Reset mid-strobe shall abort the strobe, with no extra writeIn or read pulse after release; a captured word not yet consumed shall be lost.

Verification
REQ-043 hostInSel=3, hostInData=11'h155, full=0 -> writeIn=4'b0001 at index 3 for one cycle, inData=11'h155, inCount=1, hostInReady low for 2 cycles.
REQ-044 hostInSel=1 with default mask -> accepted in 1 cycle, writeIn stays 0, badSel=1, inCount=0; clearFlags -> badSel=0.
REQ-045 full[0]=1, hostInSel=0 held valid for 1024 cycles -> hostInReady=0 throughout, stall=1 on cycle 1024; full[0]=0 -> word written.
REQ-046 dataReady=1, outData=11'h7FF, dataFrom=2, hostOutReady=0 -> hostOutData=11'h7FF, hostOutFrom=2, read exactly one pulse, no second read until host consumes.
REQ-047 Input and output streams of 4 words each run concurrently, with rst=0 asserted during an IN_STROBE cycle -> writeIn drops the same cycle, all outputs at reset values, and normal operation resumes after release.
REQ-048 inCount preset to 65535 via 65535 writes (or forced) and one more write -> inCount=0.
